// File: rtl/etch_pkg.sv
// rtl/etch_pkg.sv - shared FSM states, default geometry and pixel-address helper for the etch cursor path
package etch_pkg;

  localparam int ETCH_H_RES   = 160;
  localparam int ETCH_V_RES   = 120;
  localparam int ETCH_COLOR_W = 12;

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_WRITE = 2'd2,
    ST_CLEAR = 2'd3
  } etch_state_e;

  function automatic logic [31:0] pix_addr(input logic [7:0] x, input logic [6:0] y,
                                           input int unsigned h_res);
    return 32'(y) * h_res + 32'(x);
  endfunction

endpackage

// File: rtl/etch_axis_tracker.sv
// rtl/etch_axis_tracker.sv - per-axis prev/delta step tracker
// ETCH_DETENT_DIV_EN adds a 2-bit edge accumulator: one move per 4 same-direction edges
module etch_axis_tracker (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_sync,
  input  logic [7:0] i_count,
  input  logic       i_consume,
  output logic       o_pending,
  output logic       o_dir_neg,
  output logic       o_move
);

  logic [7:0] r_prev;
  logic [7:0] w_delta;

  // delta is read as signed, so bit 7 is the direction
  assign w_delta   = i_count - r_prev;
  assign o_pending = |w_delta;
  assign o_dir_neg = w_delta[7];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prev <= '0;
    end else if (i_sync) begin
      r_prev <= i_count;
    end else if (i_consume) begin
      r_prev <= o_dir_neg ? (r_prev - 8'd1) : (r_prev + 8'd1);
    end
  end

`ifdef ETCH_DETENT_DIV_EN
  logic [1:0] r_acc;
  logic       r_acc_neg;

  assign o_move = o_pending && (r_acc == 2'd3) && (r_acc_neg == o_dir_neg);

  // a reversal restarts the count with the current edge as the first of four
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc     <= 2'd0;
      r_acc_neg <= 1'b0;
    end else if (i_consume) begin
      if (r_acc_neg != o_dir_neg) begin
        r_acc     <= 2'd1;
        r_acc_neg <= o_dir_neg;
      end else begin
        r_acc <= r_acc + 2'd1;
      end
    end
  end
`else
  assign o_move = o_pending;
`endif

endmodule

// File: rtl/etch_cursor_ctrl.sv
// rtl/etch_cursor_ctrl.sv - decoder counts to saturated cursor moves and pixel writes, with clear sweep
// Optional ETCH_DETENT_DIV_EN divides decoder edges by 4 inside etch_axis_tracker
module etch_cursor_ctrl
  import etch_pkg::*;
#(
  parameter int                 H_RES    = ETCH_H_RES,
  parameter int                 V_RES    = ETCH_V_RES,
  parameter int                 COLOR_W  = ETCH_COLOR_W,
  parameter logic [COLOR_W-1:0] BG_COLOR = '0,
  parameter int                 ADDR_W   = 15
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [7:0]         i_x_count,
  input  logic [7:0]         i_y_count,
  input  logic               i_clear_req,
  input  logic [COLOR_W-1:0] i_pen_color,
  input  logic               i_wr_ready,
  output logic               o_wr_valid,
  output logic [ADDR_W-1:0]  o_wr_addr,
  output logic [COLOR_W-1:0] o_wr_data,
  output logic [7:0]         o_cursor_x,
  output logic [6:0]         o_cursor_y,
  output logic               o_busy
);

  localparam logic [1:0]        S_SYNC    = ST_SYNC;
  localparam logic [1:0]        S_IDLE    = ST_IDLE;
  localparam logic [1:0]        S_WRITE   = ST_WRITE;
  localparam logic [1:0]        S_CLEAR   = ST_CLEAR;
  localparam logic [7:0]        X_MAX     = 8'(H_RES - 1);
  localparam logic [6:0]        Y_MAX     = 7'(V_RES - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);

  logic [1:0]         r_state;
  logic [7:0]         r_cur_x;
  logic [6:0]         r_cur_y;
  logic               r_rr_y;
  logic               r_clr_pend;
  logic [ADDR_W-1:0]  r_wr_addr;
  logic [COLOR_W-1:0] r_wr_data;

  logic       w_x_pend, w_x_neg, w_x_move;
  logic       w_y_pend, w_y_neg, w_y_move;
  logic       w_step, w_pick_x, w_moved;
  logic [7:0] w_nx;
  logic [6:0] w_ny;

  etch_axis_tracker u_x_axis (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_sync    (r_state == S_SYNC),
    .i_count   (i_x_count),
    .i_consume (w_step && w_pick_x),
    .o_pending (w_x_pend),
    .o_dir_neg (w_x_neg),
    .o_move    (w_x_move)
  );

  etch_axis_tracker u_y_axis (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_sync    (r_state == S_SYNC),
    .i_count   (i_y_count),
    .i_consume (w_step && !w_pick_x),
    .o_pending (w_y_pend),
    .o_dir_neg (w_y_neg),
    .o_move    (w_y_move)
  );

  // a pending clear pre-empts steps; round-robin pointer only matters when both axes wait
  assign w_step   = (r_state == S_IDLE) && !r_clr_pend && (w_x_pend || w_y_pend);
  assign w_pick_x = w_x_pend && !(w_y_pend && r_rr_y);

  always_comb begin
    w_nx = r_cur_x;
    w_ny = r_cur_y;
    if (w_pick_x) begin
      if (w_x_move && !w_x_neg && (r_cur_x != X_MAX))     w_nx = r_cur_x + 8'd1;
      else if (w_x_move && w_x_neg && (r_cur_x != 8'd0))  w_nx = r_cur_x - 8'd1;
    end else begin
      if (w_y_move && !w_y_neg && (r_cur_y != Y_MAX))     w_ny = r_cur_y + 7'd1;
      else if (w_y_move && w_y_neg && (r_cur_y != 7'd0))  w_ny = r_cur_y - 7'd1;
    end
  end

  assign w_moved = (w_nx != r_cur_x) || (w_ny != r_cur_y);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_SYNC;
      r_cur_x    <= 8'(H_RES / 2);
      r_cur_y    <= 7'(V_RES / 2);
      r_rr_y     <= 1'b0;
      r_clr_pend <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
    end else begin
      if (i_clear_req) r_clr_pend <= 1'b1;
      case (r_state)
        S_SYNC: r_state <= S_IDLE;
        S_IDLE: begin
          if (r_clr_pend) begin
            r_clr_pend <= i_clear_req;
            r_wr_addr  <= '0;
            r_wr_data  <= BG_COLOR;
            r_state    <= S_CLEAR;
          end else if (w_step) begin
            if (w_x_pend && w_y_pend) r_rr_y <= !r_rr_y;
            if (w_moved) begin
              r_cur_x   <= w_nx;
              r_cur_y   <= w_ny;
              r_wr_addr <= ADDR_W'(pix_addr(w_nx, w_ny, H_RES));
              r_wr_data <= i_pen_color;
              r_state   <= S_WRITE;
            end
          end
        end
        S_WRITE: if (i_wr_ready) r_state <= S_IDLE;
        S_CLEAR: begin
          if (i_wr_ready) begin
            if (r_wr_addr == LAST_ADDR) r_state <= S_IDLE;
            else                        r_wr_addr <= r_wr_addr + ADDR_W'(1);
          end
        end
        default: r_state <= S_SYNC;
      endcase
    end
  end

  assign o_wr_valid = (r_state == S_WRITE) || (r_state == S_CLEAR);
  assign o_busy     = (r_state == S_CLEAR);
  assign o_wr_addr  = r_wr_addr;
  assign o_wr_data  = r_wr_data;
  assign o_cursor_x = r_cur_x;
  assign o_cursor_y = r_cur_y;

endmodule
